// File: rtl/fifo_pkg.sv
// Shared types for the FIFO reader: default data width and output buffer occupancy encoding.
package fifo_pkg;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } occ_e;
endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry register queue with registered head; push and pop both resolve on the same edge.
// The caller never pushes into a full queue unless it also pops; pop while empty is ignored.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_dat_i,
    input  logic              pop_i,
    output logic [1:0]        occ_o,
    output logic [DATA_W-1:0] head_o
);
    occ_e              occ_q, occ_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case (occ_q)
            S_EMPTY: begin
                if (push_i) begin
                    head_d = push_dat_i;
                    occ_d  = S_ONE;
                end
            end
            S_ONE: begin
                // Simultaneous push/pop: the new word replaces the leaving head directly.
                if (push_i && pop_i) begin
                    head_d = push_dat_i;
                end else if (push_i) begin
                    tail_d = push_dat_i;
                    occ_d  = S_TWO;
                end else if (pop_i) begin
                    occ_d  = S_EMPTY;
                end
            end
            S_TWO: begin
                if (pop_i) begin
                    head_d = tail_q;
                    if (push_i) begin
                        tail_d = push_dat_i;
                    end else begin
                        occ_d  = S_ONE;
                    end
                end
            end
            default: occ_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= S_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = head_q;
endmodule

// File: rtl/fifo_reader.sv
// Drains a read-latency-1 FIFO into a registered valid/ready stream (rd to m_valid: 2 cycles);
// rd throttles on buffer space, wr and rst. FIFO_READER_STATS_EN adds the rd_count handshake counter.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              empty,
    input  logic              wr,
    input  logic [DATA_W-1:0] dout,
    output logic              rd,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [15:0]       rd_count
`endif
);
    logic       inflight_q, inflight_d;
    logic [1:0] occ;
    logic       pop;
    logic [2:0] slots_used;

    assign m_valid = (occ != S_EMPTY);
    assign pop     = m_valid && m_ready;

    // A pop at this edge frees a slot for the word this rd will return next cycle.
    assign slots_used = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd         = !empty && !wr && !rst && (slots_used < 3'd2);
    assign inflight_d = rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_skid_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push_i     (inflight_q),
        .push_dat_i (dout),
        .pop_i      (pop),
        .occ_o      (occ),
        .head_o     (m_data)
    );

`ifdef FIFO_READER_STATS_EN
    logic [15:0] rd_count_q, rd_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        if (pop) begin
            rd_count_d = rd_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= 16'd0;
        end else begin
            rd_count_q <= rd_count_d;
        end
    end

    assign rd_count = rd_count_q;
`endif
endmodule
